// File: rtl/pwm_cfg_scheduler.sv
// pwm_cfg_scheduler
// Shadow/active register bank for the 16-channel PWM datapath, plus the PWM
// period timebase. SPI register writes land in shadow registers. The shadow set
// is copied to the active outputs in one clock, and only right after a period
// wrap, so that duty and enable changes never take effect mid-period.
module pwm_cfg_scheduler #(
    parameter int DIV  = 4,   // clk cycles per PWM counter step (>=1)
    parameter int NREG = 5    // implemented register addresses 0..NREG-1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [6:0]  wr_addr,
    input  logic [7:0]  wr_data,
    output logic        wr_err,
    output logic [15:0] en_out,
    output logic [15:0] en_pwm,
    output logic [7:0]  duty,
    output logic [7:0]  pwm_cnt,
    output logic        period_start,
    output logic        cfg_update,
    output logic        pending
);

    // Prescaler width; a DIV of 1 still needs a 1-bit register.
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    // Number of physical shadow registers backing the output map.
    localparam int NSHADOW = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    state_t                 state_reg;
    logic [PW-1:0]          presc_reg;
    logic [7:0]             pwm_cnt_reg;
    logic                   period_start_reg;
    logic                   cfg_update_reg;
    logic                   pending_reg;
    logic                   wr_err_reg;
    logic [15:0]            en_out_reg;
    logic [15:0]            en_pwm_reg;
    logic [7:0]             duty_reg;
    logic [NSHADOW*8-1:0]   shadow_flat;

    logic step;
    logic wrap;
    logic wr_accept;
    logic addr_ok;
    logic wr_hit;

    // The only stall point is the single COMMIT cycle, so the handshake is
    // decoded straight from the state register rather than registered; that
    // lets wr_ready rise in the very first cycle after reset.
    assign wr_ready  = (state_reg != COMMIT) && !rst;
    assign wr_accept = wr_valid && wr_ready;
    assign addr_ok   = (wr_addr < 7'(NREG));
    assign wr_hit    = wr_accept && addr_ok;

    assign step = (presc_reg == PW'(DIV - 1));
    assign wrap = step && (pwm_cnt_reg == 8'd255);

    assign en_out       = en_out_reg;
    assign en_pwm       = en_pwm_reg;
    assign duty         = duty_reg;
    assign pwm_cnt      = pwm_cnt_reg;
    assign period_start = period_start_reg;
    assign cfg_update   = cfg_update_reg;
    assign pending      = pending_reg;
    assign wr_err       = wr_err_reg;

    // Timebase: prescaler divides clk by DIV, pwm_cnt steps mod 256 and
    // period_start marks the first cycle of each new period (pwm_cnt==0).
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_reg        <= '0;
            pwm_cnt_reg      <= 8'd0;
            period_start_reg <= 1'b0;
        end else begin
            period_start_reg <= wrap;
            if (step) begin
                presc_reg   <= '0;
                pwm_cnt_reg <= pwm_cnt_reg + 8'd1;
            end else begin
                presc_reg   <= presc_reg + 1'b1;
            end
        end
    end

    // One shadow register per implemented address; last accepted write wins.
    genvar gi;
    generate
        for (gi = 0; gi < NSHADOW; gi++) begin : g_shadow
            logic [7:0] data_reg;

            // Capture write data on an accepted write to this address.
            always_ff @(posedge clk) begin
                if (rst) begin
                    data_reg <= 8'd0;
                end else if (wr_hit && (wr_addr == 7'(gi))) begin
                    data_reg <= wr_data;
                end
            end

            assign shadow_flat[gi*8 +: 8] = data_reg;
        end
    endgenerate

    // Commit FSM: IDLE -> PENDING on a write to an implemented register,
    // PENDING -> COMMIT on the period wrap, COMMIT loads all active registers
    // at its closing edge and returns to IDLE. A write accepted on the wrap
    // edge already sits in the shadow bank when COMMIT copies it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            cfg_update_reg <= 1'b0;
            pending_reg    <= 1'b0;
            wr_err_reg     <= 1'b0;
            en_out_reg     <= 16'd0;
            en_pwm_reg     <= 16'd0;
            duty_reg       <= 8'd0;
        end else begin
            wr_err_reg     <= wr_accept && !addr_ok;
            cfg_update_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (wr_hit) begin
                        state_reg   <= PENDING;
                        pending_reg <= 1'b1;
                    end
                end
                PENDING: begin
                    if (wrap) begin
                        state_reg      <= COMMIT;
                        cfg_update_reg <= 1'b1;
                    end
                end
                COMMIT: begin
                    en_out_reg  <= {shadow_flat[15:8],  shadow_flat[7:0]};
                    en_pwm_reg  <= {shadow_flat[31:24], shadow_flat[23:16]};
                    duty_reg    <= shadow_flat[39:32];
                    state_reg   <= IDLE;
                    pending_reg <= 1'b0;
                end
                default: begin
                    state_reg   <= IDLE;
                    pending_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_cfg_scheduler.sv
// Directed testbench for pwm_cfg_scheduler with DIV=4 (1024 clk per period).
// Inputs are driven and outputs sampled on the falling clock edge; cyc counts
// cycles since the last reset release, so cycle 1024*k is the first cycle of
// period k and the cycle in which a commit (cfg_update) is visible.
module tb_pwm_cfg_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [6:0]  wr_addr = 7'd0;
    logic [7:0]  wr_data = 8'd0;
    logic        wr_err;
    logic [15:0] en_out;
    logic [15:0] en_pwm;
    logic [7:0]  duty;
    logic [7:0]  pwm_cnt;
    logic        period_start;
    logic        cfg_update;
    logic        pending;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int n_upd = 0;
    int n_ps  = 0;
    int stalls;

    always #5 clk = ~clk;

    pwm_cfg_scheduler #(.DIV(4), .NREG(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_err       (wr_err),
        .en_out       (en_out),
        .en_pwm       (en_pwm),
        .duty         (duty),
        .pwm_cnt      (pwm_cnt),
        .period_start (period_start),
        .cfg_update   (cfg_update),
        .pending      (pending)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance one cycle and tally the pulses seen in the new cycle.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (cfg_update)   n_upd++;
        if (period_start) n_ps++;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    // Hold a write until accepted (bounded), returning the number of stalled cycles.
    task automatic wr(input logic [6:0] a, input logic [7:0] d, output int nstall);
        bit done;
        done     = 1'b0;
        nstall   = 0;
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        for (int i = 0; i < 8 && !done; i++) begin
            if (wr_ready) done = 1'b1;
            else          nstall++;
            tick();
        end
        wr_valid = 1'b0;
        check("wr_accepted", {31'd0, done}, 32'd1);
        $display("write addr=0x%02h data=0x%02h stalls=%0d now cyc=%0d", a, d, nstall, cyc);
    endtask

    initial begin
        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        #1;
        check("rst_wr_ready",     {31'd0, wr_ready},     32'd1);
        check("rst_en_out",       {16'd0, en_out},       32'd0);
        check("rst_en_pwm",       {16'd0, en_pwm},       32'd0);
        check("rst_duty",         {24'd0, duty},         32'd0);
        check("rst_pwm_cnt",      {24'd0, pwm_cnt},      32'd0);
        check("rst_period_start", {31'd0, period_start}, 32'd0);
        check("rst_cfg_update",   {31'd0, cfg_update},   32'd0);
        check("rst_pending",      {31'd0, pending},      32'd0);
        check("rst_wr_err",       {31'd0, wr_err},       32'd0);

        // First period_start 1024 clk after release, no commit while idle.
        n_ps = 0;
        n_upd = 0;
        while (!period_start && cyc < 2000) tick();
        check("first_ps_cyc",  cyc, 32'd1024);
        check("first_ps_cnt",  {24'd0, pwm_cnt},    32'd0);
        check("idle_no_upd",   {31'd0, cfg_update}, 32'd0);

        // ---------------- duty write mid-period ----------------
        run_to(1100);
        check("cnt_at_1100", {24'd0, pwm_cnt}, 32'd19);
        wr(7'h04, 8'h80, stalls);
        check("t2_pending_set", {31'd0, pending}, 32'd1);
        check("t2_duty_early",  {24'd0, duty},    32'd0);
        n_upd = 0;
        run_to(2047);
        check("t2_duty_hold",   {24'd0, duty},    32'd0);
        check("t2_no_early_upd", n_upd,           32'd0);
        tick();  // 2048: commit cycle
        check("t2_ps",          {31'd0, period_start}, 32'd1);
        check("t2_upd",         {31'd0, cfg_update},   32'd1);
        check("t2_duty_commit", {24'd0, duty},         32'd0);
        check("t2_ready_low",   {31'd0, wr_ready},     32'd0);
        tick();  // 2049: new values live
        check("t2_duty_new",    {24'd0, duty},       32'h80);
        check("t2_pending_clr", {31'd0, pending},    32'd0);
        check("t2_upd_clr",     {31'd0, cfg_update}, 32'd0);
        check("t2_cnt",         {24'd0, pwm_cnt},    32'd0);
        run_to(2100);
        check("t2_upd_once",    n_upd, 32'd1);

        // ---------------- rewrite: last write wins ----------------
        wr(7'h00, 8'hFF, stalls);
        wr(7'h02, 8'h0F, stalls);
        wr(7'h00, 8'h3C, stalls);
        check("t3_en_out_pre", {16'd0, en_out}, 32'd0);
        run_to(3073);
        check("t3_en_out",  {16'd0, en_out},  32'h003C);
        check("t3_en_pwm",  {16'd0, en_pwm},  32'h000F);
        check("t3_duty",    {24'd0, duty},    32'h80);
        check("t3_pending", {31'd0, pending}, 32'd0);

        // ---------------- write in wrap cycle, write held in COMMIT ----------------
        run_to(3200);
        wr(7'h01, 8'h12, stalls);
        run_to(4095);
        check("t4_wrap_cnt", {24'd0, pwm_cnt}, 32'd255);
        wr(7'h03, 8'h34, stalls);            // accepted on the wrap edge
        check("t4_wrap_stall", stalls, 32'd0);
        check("t4_upd",        {31'd0, cfg_update},   32'd1);
        check("t4_ps",         {31'd0, period_start}, 32'd1);
        check("t4_ready_low",  {31'd0, wr_ready},     32'd0);
        wr(7'h04, 8'h55, stalls);            // held through COMMIT
        check("t4_commit_stall", stalls, 32'd1);
        check("t4_en_out",  {16'd0, en_out},  32'h123C);
        check("t4_en_pwm",  {16'd0, en_pwm},  32'h340F);
        check("t4_duty_old",{24'd0, duty},    32'h80);
        check("t4_pending", {31'd0, pending}, 32'd1);
        n_upd = 0;
        run_to(5121);
        check("t4_upd_next", n_upd, 32'd1);
        check("t4_duty_new", {24'd0, duty},    32'h55);
        check("t4_pend_clr", {31'd0, pending}, 32'd0);

        // ---------------- unimplemented address ----------------
        run_to(5200);
        wr(7'h05, 8'hAA, stalls);
        check("t5_wr_err",     {31'd0, wr_err},  32'd1);
        check("t5_pending",    {31'd0, pending}, 32'd0);
        tick();
        check("t5_wr_err_end", {31'd0, wr_err},  32'd0);
        n_upd = 0;
        run_to(6145);
        check("t5_no_upd",  n_upd, 32'd0);
        check("t5_en_out",  {16'd0, en_out}, 32'h123C);
        wr(7'h04, 8'h66, stalls);
        run_to(7169);
        check("t5_en_out_after", {16'd0, en_out}, 32'h123C);
        check("t5_en_pwm_after", {16'd0, en_pwm}, 32'h340F);
        check("t5_duty_after",   {24'd0, duty},   32'h66);

        // ---------------- reset discards pending write ----------------
        run_to(7300);
        wr(7'h04, 8'h40, stalls);
        check("t6_pending_set", {31'd0, pending}, 32'd1);
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("t6_ready_in_rst", {31'd0, wr_ready}, 32'd0);
        tick();
        rst = 1'b0;
        cyc = 0;
        #1;
        check("t6_duty",    {24'd0, duty},     32'd0);
        check("t6_pending", {31'd0, pending},  32'd0);
        check("t6_cnt",     {24'd0, pwm_cnt},  32'd0);
        check("t6_en_out",  {16'd0, en_out},   32'd0);
        check("t6_ready",   {31'd0, wr_ready}, 32'd1);
        n_upd = 0;
        n_ps  = 0;
        run_to(1030);
        check("t6_no_upd",   n_upd, 32'd0);
        check("t6_one_ps",   n_ps,  32'd1);
        check("t6_duty_end", {24'd0, duty},    32'd0);
        check("t6_cnt_end",  {24'd0, pwm_cnt}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
